// File: rtl/ifns_enc_arbiter_if.sv
// Request/codeword bus between the word sources, the shared IFNS encoder arbiter
// and the crosstalk-avoidance bus driver.
interface ifns_enc_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic                  en;
  logic [NUM_REQ-1:0]    req_valid;
  logic [14*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  code_valid;
  logic                  code_ready;
  logic [20:1]           codeout;
  logic [ID_W-1:0]       code_src;
  logic                  busy;

  modport slave (
    input  en, req_valid, req_data, code_ready,
    output req_ready, code_valid, codeout, code_src, busy
  );

  modport master (
    output en, req_valid, req_data, code_ready,
    input  req_ready, code_valid, codeout, code_src, busy
  );
endinterface

// File: rtl/ifns_enc_arbiter.sv
// Round-robin arbiter with bounded burst locking in front of one shared
// IFNS 14b->20b encoder; registered codeword is tagged with its source index.

// Fibonacci-numeral (Zeckendorf) greedy encoder: weights 1,2,3,5,... at bits
// [1..20]; the greedy walk guarantees no two adjacent ones in the codeword.
module encoderIFNS_14di_core (
  input  logic [13:0] din,
  output logic [20:1] dout
);
  logic [14:0] rem;
  logic [14:0] w_hi;
  logic [14:0] w_lo;
  logic [14:0] w_nx;

  always_comb begin
    dout = '0;
    rem  = {1'b0, din};
    w_hi = 15'd10946;
    w_lo = 15'd6765;
    w_nx = '0;
    for (int k = 20; k >= 1; k--) begin
      if (rem >= w_hi) begin
        dout[5'(k)] = 1'b1;
        rem         = rem - w_hi;
      end
      w_nx = w_hi - w_lo;
      w_hi = w_lo;
      w_lo = w_nx;
    end
  end
endmodule

// state   | meaning
// S_IDLE  | round-robin search from rr_ptr for the next requester
// S_BURST | owner locked; only the owner may transfer until release
module ifns_enc_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int MAX_BURST = 4
) (
  input logic               clock,
  input logic               rst_n,
  ifns_enc_arbiter_if.slave bus
);
  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [3:0]      burst_cnt_q, burst_cnt_d;
  logic            code_valid_q, code_valid_d;
  logic [20:1]     codeout_q, codeout_d;
  logic [ID_W-1:0] code_src_q, code_src_d;

  logic            slot_free;
  logic            grant_ok;
  logic            found;
  logic [ID_W-1:0] pick;
  logic [ID_W-1:0] cand_id;
  int              cand;
  logic            gnt_en;
  logic [ID_W-1:0] gnt_id;
  logic [13:0]     core_in;
  logic [20:1]     core_out;

  function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] p);
    return (p == ID_W'(NUM_REQ-1)) ? '0 : p + 1'b1;
  endfunction

  assign slot_free = !code_valid_q || bus.code_ready;
  assign grant_ok  = slot_free && bus.en;

  always_comb begin
    found   = 1'b0;
    pick    = '0;
    cand    = 0;
    cand_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_id = ID_W'(cand);
      if (!found && bus.req_valid[cand_id]) begin
        found = 1'b1;
        pick  = cand_id;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    gnt_en      = 1'b0;
    gnt_id      = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_ok && found) begin
          gnt_en = 1'b1;
          gnt_id = pick;
          if (MAX_BURST > 1) begin
            state_d     = S_BURST;
            owner_d     = pick;
            burst_cnt_d = 4'd1;
          end else begin
            rr_ptr_d = ptr_inc(pick);
          end
        end
      end
      S_BURST: begin
        // en low releases the lock even while the output slot is stalled
        if (!bus.en) begin
          state_d     = S_IDLE;
          rr_ptr_d    = ptr_inc(owner_q);
          burst_cnt_d = '0;
        end else if (slot_free) begin
          if (bus.req_valid[owner_q]) begin
            gnt_en      = 1'b1;
            gnt_id      = owner_q;
            burst_cnt_d = burst_cnt_q + 4'd1;
            if (burst_cnt_q + 4'd1 == 4'(MAX_BURST)) begin
              state_d     = S_IDLE;
              rr_ptr_d    = ptr_inc(owner_q);
              burst_cnt_d = '0;
            end
          end else begin
            state_d     = S_IDLE;
            rr_ptr_d    = ptr_inc(owner_q);
            burst_cnt_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    core_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == ID_W'(i)) core_in = bus.req_data[14*i +: 14];
    end
  end

  encoderIFNS_14di_core u_core (
    .din  (core_in),
    .dout (core_out)
  );

  always_comb begin
    code_valid_d = code_valid_q;
    codeout_d    = codeout_q;
    code_src_d   = code_src_q;
    if (gnt_en) begin
      code_valid_d = 1'b1;
      codeout_d    = core_out;
      code_src_d   = gnt_id;
    end else if (bus.code_ready) begin
      code_valid_d = 1'b0;
    end
  end

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = rst_n && gnt_en && (gnt_id == ID_W'(i));
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      burst_cnt_q  <= '0;
      code_valid_q <= 1'b0;
      codeout_q    <= '0;
      code_src_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      burst_cnt_q  <= burst_cnt_d;
      code_valid_q <= code_valid_d;
      codeout_q    <= codeout_d;
      code_src_q   <= code_src_d;
    end
  end

  assign bus.code_valid = code_valid_q;
  assign bus.codeout    = codeout_q;
  assign bus.code_src   = code_src_q;
  assign bus.busy       = (state_q == S_BURST) || code_valid_q;
endmodule

// File: tb/tb_ifns_enc_arbiter.sv
// Randomized and directed bench for ifns_enc_arbiter against a behavioural
// arbitration model and a Fibonacci-decode check of every codeword.
module tb_ifns_enc_arbiter;
  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int MAXB = 4;

  logic clock = 1'b0;
  logic rst_n;
  always #5 clock = ~clock;

  ifns_enc_arbiter_if #(.NUM_REQ(N), .ID_W(IDW)) bus ();

  ifns_enc_arbiter #(.NUM_REQ(N), .ID_W(IDW), .MAX_BURST(MAXB)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // reference model state
  bit m_valid;
  int m_data;
  int m_src;
  bit m_burst;
  int m_owner;
  int m_used;
  int m_ptr;
  int last_grant;

  function automatic int fib_decode(input logic [20:1] c);
    int w[1:20];
    int s;
    w[1] = 1;
    w[2] = 2;
    for (int k = 3; k <= 20; k++) w[k] = w[k-1] + w[k-2];
    s = 0;
    for (int k = 1; k <= 20; k++) if (c[k] === 1'b1) s += w[k];
    return s;
  endfunction

  function automatic bit code_ok(input logic [20:1] c, input int data);
    if ($isunknown(c)) return 1'b0;
    for (int k = 1; k < 20; k++) if (c[k] && c[k+1]) return 1'b0;
    return fib_decode(c) == data;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_src = 0;
    m_burst = 0; m_owner = 0; m_used = 0; m_ptr = 0;
    last_grant = -1;
  endtask

  function automatic int model_grant();
    if (!bus.en || !(!m_valid || bus.code_ready)) return -1;
    if (m_burst) return bus.req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      int c = (m_ptr + k) % N;
      if (bus.req_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input int g);
    bit free;
    free = !m_valid || bus.code_ready;
    if (g >= 0) begin
      m_valid = 1; m_src = g; m_data = int'(bus.req_data[14*g +: 14]);
    end else if (m_valid && bus.code_ready) begin
      m_valid = 0;
    end
    if (!m_burst) begin
      if (g >= 0) begin
        if (MAXB > 1) begin m_burst = 1; m_owner = g; m_used = 1; end
        else m_ptr = (g + 1) % N;
      end
    end else if (!bus.en) begin
      m_burst = 0; m_ptr = (m_owner + 1) % N;
    end else if (free) begin
      if (g >= 0) begin
        m_used++;
        if (m_used == MAXB) begin m_burst = 0; m_ptr = (m_owner + 1) % N; end
      end else begin
        m_burst = 0; m_ptr = (m_owner + 1) % N;
      end
    end
  endtask

  // one clock: compare at the falling edge, advance the model at the rising edge
  task automatic tick();
    int g;
    logic [N-1:0] exp_rdy;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.req_ready !== exp_rdy) begin
      errors++; $display("FAIL req_ready: got %b want %b @%0t", bus.req_ready, exp_rdy, $time);
    end
    checks++;
    if (bus.code_valid !== m_valid) begin
      errors++; $display("FAIL code_valid: got %b want %b @%0t", bus.code_valid, m_valid, $time);
    end
    checks++;
    if (bus.busy !== (m_burst || m_valid)) begin
      errors++; $display("FAIL busy: got %b want %b @%0t", bus.busy, m_burst || m_valid, $time);
    end
    if (m_valid) begin
      checks++;
      if (bus.code_src !== IDW'(m_src)) begin
        errors++; $display("FAIL code_src: got %0d want %0d @%0t", bus.code_src, m_src, $time);
      end
      checks++;
      if (!code_ok(bus.codeout, m_data)) begin
        errors++; $display("FAIL codeout: got %h (decodes %0d) want data %0d @%0t",
                           bus.codeout, fib_decode(bus.codeout), m_data, $time);
      end
    end
    @(posedge clock);
    model_step(g);
    last_grant = g;
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clock);
    #1 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (bus.code_valid !== 1'b0 || bus.codeout !== 20'h0 || bus.code_src !== '0 ||
        bus.busy !== 1'b0 || bus.req_ready !== '0) begin
      errors++;
      $display("FAIL %s: valid=%b code=%h src=%0d busy=%b rdy=%b want all zero",
               name, bus.code_valid, bus.codeout, bus.code_src, bus.busy, bus.req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.en = 1'b1; bus.req_valid = '1; bus.req_data = '0; bus.code_ready = 1'b1;
    @(posedge clock);
    #1 check_outputs_zero("reset_values");
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    apply_reset();
    bus.en = 1; bus.code_ready = 1; bus.req_valid = 4'b0001; bus.req_data = '0;
    tick();
    checks++;
    if (bus.code_valid !== 1'b1 || bus.code_src !== 2'd0 || bus.codeout !== 20'h0) begin
      errors++;
      $display("FAIL single_word: valid=%b src=%0d code=%h want 1/0/00000",
               bus.code_valid, bus.code_src, bus.codeout);
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int word;
    apply_reset();
    bus.en = 1; bus.code_ready = 1; bus.req_valid = '1;
    word = 1;
    for (int c = 0; c < 60 && word <= 17; c++) begin
      for (int i = 0; i < N; i++) bus.req_data[14*i +: 14] = 14'(word);
      tick();
      if (last_grant >= 0) begin
        checks++;
        if (bus.code_src !== IDW'(((word - 1) / MAXB) % N) || !code_ok(bus.codeout, word)) begin
          errors++;
          $display("FAIL rr_sequence word %0d: src=%0d code=%h want src %0d",
                   word, bus.code_src, bus.codeout, ((word - 1) / MAXB) % N);
        end
        word++;
      end
    end
    checks++;
    if (word != 18) begin
      errors++; $display("FAIL rr_throughput: got %0d words want 17", word - 1);
    end
  endtask

  task automatic test_stall();
    logic [20:1] saved_code;
    logic [IDW-1:0] saved_src, nxt;
    int ones;
    bit done;
    apply_reset();
    bus.en = 1; bus.code_ready = 1;
    for (int i = 0; i < N; i++) bus.req_data[14*i +: 14] = 14'($urandom);
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = 4'b0011;
    tick();
    saved_code = bus.codeout;
    saved_src  = bus.code_src;
    bus.code_ready = 0;
    repeat (3) begin
      tick();
      checks++;
      if (bus.codeout !== saved_code || bus.code_src !== saved_src || bus.code_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold: code=%h src=%0d valid=%b want %h/%0d/1",
                 bus.codeout, bus.code_src, bus.code_valid, saved_code, saved_src);
      end
    end
    bus.code_ready = 1;
    ones = 2; done = 0; nxt = 2'd3;
    for (int c = 0; c < 10 && !done; c++) begin
      tick();
      if (last_grant >= 0) begin
        if (bus.code_src === 2'd1) ones++;
        else begin done = 1; nxt = bus.code_src; end
      end
    end
    checks++;
    if (!done || ones != MAXB) begin
      errors++; $display("FAIL stall_burst_len: got %0d words want %0d", ones, MAXB);
    end
    checks++;
    if (nxt !== 2'd0) begin
      errors++; $display("FAIL stall_next_src: got %0d want 0", nxt);
    end
  endtask

  task automatic test_early_release();
    int threes;
    bit done;
    logic [IDW-1:0] nxt;
    apply_reset();
    bus.en = 1; bus.code_ready = 1;
    for (int i = 0; i < N; i++) bus.req_data[14*i +: 14] = 14'($urandom);
    bus.req_valid = 4'b0100;
    tick();
    tick();
    bus.req_valid = 4'b1000;
    tick();
    tick();
    checks++;
    if (bus.code_valid !== 1'b1 || bus.code_src !== 2'd3) begin
      errors++; $display("FAIL release_to_3: valid=%b src=%0d want 1/3", bus.code_valid, bus.code_src);
    end
    bus.req_valid = 4'b1010;
    threes = 1; done = 0; nxt = 2'd2;
    for (int c = 0; c < 14 && !done; c++) begin
      tick();
      if (last_grant >= 0) begin
        if (bus.code_src === 2'd3) threes++;
        else begin done = 1; nxt = bus.code_src; end
      end
    end
    checks++;
    if (!done || threes != MAXB || nxt !== 2'd1) begin
      errors++; $display("FAIL ptr_after_3: words=%0d next=%0d want %0d then 1", threes, nxt, MAXB);
    end
  endtask

  task automatic test_en_low();
    apply_reset();
    bus.en = 1; bus.code_ready = 0; bus.req_valid = '1;
    for (int i = 0; i < N; i++) bus.req_data[14*i +: 14] = 14'($urandom);
    tick();
    bus.en = 0;
    repeat (3) tick();
    checks++;
    if (bus.code_valid !== 1'b1) begin
      errors++; $display("FAIL en_low_pending: valid=%b want 1", bus.code_valid);
    end
    bus.code_ready = 1;
    tick();
    checks++;
    if (bus.code_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL en_low_drain: valid=%b busy=%b want 0/0", bus.code_valid, bus.busy);
    end
    tick();
    bus.en = 1;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.en = 1; bus.code_ready = 1; bus.req_valid = 4'b0100;
    for (int i = 0; i < N; i++) bus.req_data[14*i +: 14] = 14'($urandom);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("reset_mid_burst");
    rst_n = 1'b1;
    model_reset();
    bus.req_valid = '1;
    tick();
    checks++;
    if (bus.code_valid !== 1'b1 || bus.code_src !== 2'd0) begin
      errors++; $display("FAIL restart_src: valid=%b src=%0d want 1/0", bus.code_valid, bus.code_src);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) != 0) bus.req_valid = 4'($urandom);
      bus.en         = ($urandom_range(0, 7) != 0);
      bus.code_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) bus.req_data[14*i +: 14] = 14'($urandom);
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_early_release();
    test_en_low();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
